// File: rtl/demux_scheduler_if.sv
// Request handshake between an upstream producer and demux_scheduler.
// The producer drives destination/data with in_valid; the scheduler returns in_ready.
interface demux_scheduler_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_dest;
    logic       in_data;

    modport master (output in_valid, output in_dest, output in_data, input in_ready);
    modport slave  (input in_valid, input in_dest, input in_data, output in_ready);
endinterface

// File: rtl/demux_scheduler.sv
// Buffers (destination, data) requests in a FIFO and replays each onto the
// 1:4 demux selects/data, holding it HOLD cycles so downstream can sample it.
module demux_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    demux_scheduler_if.slave         req,
    output logic                     s1,
    output logic                     s0,
    output logic                     i,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [2:0]      mem [DEPTH];
    logic            push, pop, clear_i;

    // in_ready depends on count alone, so a pop never frees a slot in the same cycle.
    assign req.in_ready = (count != CW'(DEPTH));
    assign push         = req.in_valid && req.in_ready;
    assign busy         = (state_q == DRIVE);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        pop     = 1'b0;
        clear_i = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    hcnt_d  = HOLD_LAST;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - 1'b1;
                end else if (count != '0) begin
                    pop    = 1'b1;
                    hcnt_d = HOLD_LAST;
                end else begin
                    clear_i = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {req.in_dest, req.in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s1      <= 1'b0;
            s0      <= 1'b0;
            i       <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Selects keep their last value in IDLE; only the data line is cleared.
            if (pop) begin
                {s1, s0, i} <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + 1'b1;
            end else if (clear_i) begin
                i <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler (DEPTH=4, HOLD=2) with a presentation
// scoreboard that checks order, hold length and stability of every request.
module tb_demux_scheduler;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    // Expected values after edges e1..e10 of the back-to-back sequence.
    localparam int B2B_SEL  [10] = '{'b100, 'b001, 'b001, 'b011, 'b011, 'b101, 'b101, 'b111, 'b111, 'b110};
    localparam int B2B_BUSY [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    localparam int B2B_CNT  [10] = '{1, 1, 2, 2, 2, 1, 1, 0, 0, 0};
    // Occupancy after edges e1..e13 with in_valid held high from empty.
    localparam int BP_CNT   [13] = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3, 4, 3, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic       s1, s0, i, busy;
    logic [2:0] count;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] expq [$];
    int         run_len  = 0;
    logic [2:0] cur_val;
    logic [2:0] exp_val;

    demux_scheduler_if bus ();

    demux_scheduler #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (bus),
        .s1    (s1),
        .s0    (s0),
        .i     (i),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r);
        bus.in_valid = 1'b1;
        bus.in_dest  = r[2:1];
        bus.in_data  = r[0];
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || count !== 3'd0) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(busy !== 1'b0 || count !== 3'd0), 0);
        tick();
        check({tag, "_drained"}, 32'(expq.size()), 0);
    endtask

    // Every HOLD consecutive busy cycles form one presentation of the next queued request.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else if (busy) begin
            if (run_len % HOLD == 0) begin
                if (expq.size() == 0) begin
                    check("unexpected_present", 32'({s1, s0, i}), 'h8);
                end else begin
                    exp_val = expq.pop_front();
                    check("present", 32'({s1, s0, i}), 32'(exp_val));
                end
                cur_val = {s1, s0, i};
            end else begin
                check("hold_stable", 32'({s1, s0, i}), 32'(cur_val));
            end
            run_len++;
        end else begin
            if (run_len != 0) check("hold_len", 32'(run_len % HOLD), 0);
            run_len = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        logic acc;
        logic rdy_exp;
        logic [2:0] r;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_dest  = 2'b00;
        bus.in_data  = 1'b0;
        tick();
        tick();
        check("rst_sel",   32'({s1, s0, i}), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        tick();

        // Single request: dest 10, data 1.
        drive(3'b101);
        expq.push_back(3'b101);
        tick();
        bus.in_valid = 1'b0;
        check("single_cnt_e1",  32'(count), 1);
        check("single_busy_e1", 32'(busy), 0);
        tick();
        check("single_sel_e2",  32'({s1, s0, i}), 'b101);
        check("single_busy_e2", 32'(busy), 1);
        check("single_cnt_e2",  32'(count), 0);
        tick();
        check("single_sel_e3",  32'({s1, s0, i}), 'b101);
        check("single_busy_e3", 32'(busy), 1);
        tick();
        check("single_sel_e4",  32'({s1, s0, i}), 'b100);
        check("single_busy_e4", 32'(busy), 0);
        check("single_cnt_e4",  32'(count), 0);
        tick();

        // Back-to-back dest 00..11; edge 2 is also a simultaneous push and pop.
        for (int e = 0; e < 10; e++) begin
            if (e < 4) begin
                r = {2'(e), 1'b1};
                drive(r);
                expq.push_back(r);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            check($sformatf("b2b_sel_e%0d", e + 1),  32'({s1, s0, i}), B2B_SEL[e]);
            check($sformatf("b2b_busy_e%0d", e + 1), 32'(busy), B2B_BUSY[e]);
            check($sformatf("b2b_cnt_e%0d", e + 1),  32'(count), B2B_CNT[e]);
        end
        wait_idle("b2b_idle");

        // Backpressure: ten requests with in_valid held high from an empty FIFO.
        idx = 0;
        rdy_exp = 1'b1;
        for (int e = 0; e < 13; e++) begin
            r = 3'((idx * 3 + 1) % 8);
            drive(r);
            tick();
            if (rdy_exp) begin
                expq.push_back(r);
                idx++;
            end
            check($sformatf("bp_cnt_e%0d", e + 1),   32'(count), BP_CNT[e]);
            check($sformatf("bp_ready_e%0d", e + 1), 32'(bus.in_ready), 32'(BP_CNT[e] != DEPTH));
            rdy_exp = (BP_CNT[e] != DEPTH);
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(idx), 10);
        wait_idle("bp_idle");

        // Pointer wrap: 2*DEPTH+1 requests, alternating data 1/0.
        idx = 0;
        for (int n = 0; n < 200 && idx < 2 * DEPTH + 1; n++) begin
            r = {2'(idx % 4), 1'((idx + 1) % 2)};
            drive(r);
            acc = bus.in_ready;
            tick();
            if (acc) begin
                expq.push_back(r);
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        check("wrap_accepted", 32'(idx), 2 * DEPTH + 1);
        wait_idle("wrap_idle");

        // Reset while presenting with two requests queued, plus a push on the reset edge.
        drive(3'b111); expq.push_back(3'b111); tick();
        drive(3'b011); expq.push_back(3'b011); tick();
        drive(3'b101); expq.push_back(3'b101); tick();
        check("rstmid_busy_pre", 32'(busy), 1);
        check("rstmid_cnt_pre",  32'(count), 2);
        rst = 1'b1;
        drive(3'b110);
        expq.delete();
        tick();
        check("rstmid_sel",   32'({s1, s0, i}), 0);
        check("rstmid_busy",  32'(busy), 0);
        check("rstmid_count", 32'(count), 0);
        check("rstmid_ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            check($sformatf("rstmid_quiet_busy%0d", e), 32'(busy), 0);
            check($sformatf("rstmid_quiet_cnt%0d", e),  32'(count), 0);
        end
        check("scoreboard_empty", 32'(expq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
